// File: rtl/xnor_seq_cmp.sv
// Bit-serial word equality comparator sharing one external XNOR gate, LSB first.
// Optional build macro XSC_EARLY_ABORT_EN: finish at the first mismatching bit.
module xnor_seq_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [WIDTH-1:0] match
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] match_q, match_d;
  logic             eq_q, eq_d;
  logic             abort;

`ifdef XSC_EARLY_ABORT_EN
  assign abort = ~gate_y;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      match_q <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      match_q <= match_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    match_d = match_q;
    eq_d    = eq_q;
    gate_a  = 1'b0;
    gate_b  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          match_d = '0;
          eq_d    = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy           = 1'b1;
        gate_a         = a_q[idx_q];
        gate_b         = b_q[idx_q];
        match_d[idx_q] = gate_y;
        // eq is taken from the updated vector so the last bit counts.
        if (idx_q == LAST_IDX || abort) begin
          eq_d    = &match_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign eq    = eq_q;
  assign match = match_q;

endmodule

// File: tb/tb_xnor_seq_cmp.sv
// Bench for xnor_seq_cmp: vector table, busy-time start pokes, mid-run reset,
// result hold, and random operands against a word-level reference model.
module tb_xnor_seq_cmp;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         gate_a, gate_b, gate_y;
  logic         busy, done, eq;
  logic [W-1:0] match;

  int n_pass  = 0;
  int n_total = 0;

  xnor_seq_cmp #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .gate_a(gate_a),
    .gate_b(gate_b),
    .gate_y(gate_y),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .match (match)
  );

  // The shared external XNOR cell.
  assign gate_y = ~(gate_a ^ gate_b);

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq;
    logic [W-1:0] match;
    int           lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    else n_pass++;
  endtask

  // Word-level reference: per-bit equality, first differing bit for early finish.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic e, output logic [W-1:0] m, output int lat);
    m   = ~(av ^ bv);
    e   = (av == bv);
    lat = W;
`ifdef XSC_EARLY_ABORT_EN
    for (int i = 0; i < W; i++) begin
      if (av[i] != bv[i]) begin
        lat = i + 1;
        m   = m & W'((1 << (i + 1)) - 1);
        break;
      end
    end
`endif
  endfunction

  // Called and returns at a falling edge with the DUT idle. xl = edges from accept to done.
  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic xe, input logic [W-1:0] xm, input int xl,
                        input int p1, input int p2, input string tag);
    int           busy_n;
    int           lat;
    logic         seen;
    logic         ge;
    logic [W-1:0] gm, ga, gb, msk;
    busy_n = 0; lat = -1; seen = 1'b0; ge = 1'bx; gm = 'x; ga = '0; gb = '0;
    msk = W'((1 << xl) - 1);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1; lat = c; ge = eq; gm = match;
      end else if (busy && c < W) begin
        ga[c] = gate_a; gb[c] = gate_b;
      end
      if (c == p1 || c == p2) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (seen) break;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(xl));
    chk({tag, " eq"}, 32'(ge), 32'(xe));
    chk({tag, " match"}, 32'(gm), 32'(xm));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(xl + 1));
    chk({tag, " gate_a_seq"}, 32'(ga), 32'(av & msk));
    chk({tag, " gate_b_seq"}, 32'(gb), 32'(bv & msk));
    chk({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
    chk({tag, " eq_held"}, 32'(eq), 32'(xe));
    chk({tag, " match_held"}, 32'(match), 32'(xm));
  endtask

  initial begin
    logic         e;
    logic [W-1:0] m, av, bv;
    int           l, dn;

    tbl[0] = '{8'hA5, 8'hA5, 1'b1, 8'hFF, 8};
`ifdef XSC_EARLY_ABORT_EN
    tbl[1] = '{8'hA5, 8'hA4, 1'b0, 8'h00, 1};
    tbl[2] = '{8'h00, 8'hFF, 1'b0, 8'h00, 1};
    tbl[5] = '{8'h0F, 8'h07, 1'b0, 8'h07, 4};
`else
    tbl[1] = '{8'hA5, 8'hA4, 1'b0, 8'hFE, 8};
    tbl[2] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8};
    tbl[5] = '{8'h0F, 8'h07, 1'b0, 8'hF7, 8};
`endif
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 8};
    tbl[4] = '{8'h80, 8'h00, 1'b0, 8'h7F, 8};
    tbl[6] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 8};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset eq", 32'(eq), 32'd0);
    chk("reset match", 32'(match), 32'd0);
    chk("reset gates", {30'd0, gate_a, gate_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_cmp(tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].match, tbl[i].lat, -1, -1,
             $sformatf("tbl%0d", i));

    // Result must hold through a long idle stretch.
    do_cmp(8'h5A, 8'h5A, 1'b1, 8'hFF, W, -1, -1, "hold_setup");
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("hold eq c%0d", c), 32'(eq), 32'd1);
      chk($sformatf("hold match c%0d", c), 32'(match), 32'hFF);
      chk($sformatf("hold done c%0d", c), 32'(done), 32'd0);
      @(negedge clk);
    end

    // Start pulses while busy are ignored; the following idle cycle accepts.
    av = 8'h5A; bv = 8'hA5;
    model(av, bv, e, m, l);
    do_cmp(av, bv, e, m, l, (l > 3) ? 3 : l - 1, l, "poke");
    do_cmp(8'hA5, 8'hA5, 1'b1, 8'hFF, W, -1, -1, "after_poke");

    // Reset in RUN cycle 4 discards the comparison.
    a = 8'hC3; b = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy_done", {30'd0, busy, done}, 32'd0);
    chk("midrst eq", 32'(eq), 32'd0);
    chk("midrst match", 32'(match), 32'd0);
    chk("midrst gates", {30'd0, gate_a, gate_b}, 32'd0);
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midrst no_activity", 32'(dn), 32'd0);

    for (int i = 0; i < 40; i++) begin
      av = W'($urandom);
      case ($urandom_range(0, 2))
        0:       bv = W'($urandom);
        1:       bv = av;
        default: bv = av ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      model(av, bv, e, m, l);
      do_cmp(av, bv, e, m, l, -1, -1, $sformatf("rnd%0d a=%0h b=%0h", i, av, bv));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
